// File: rtl/zmips_pkg.sv
// Shared zmips write-back definitions: special register addresses, round-robin
// state and the write-back request record.
package zmips_pkg;

    localparam int unsigned WB_ADDR_W = 5;
    localparam int unsigned WB_DATA_W = 32;

    localparam logic [WB_ADDR_W-1:0] REG_PC_CUR   = 5'd31;
    localparam logic [WB_ADDR_W-1:0] REG_PC_SAVED = 5'd30;
    localparam int unsigned          NUM_GPR      = 30;

    // Which requester won the most recent transfer
    typedef enum logic {
        LAST_ALU = 1'b0,
        LAST_MEM = 1'b1
    } rr_state_e;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/zmips_scoreboard.sv
// Pending-write scoreboard: one bit per writable GPR, set on issue, cleared by
// the registered write-back; drives the decode-stage RAW hazard flags.
module zmips_scoreboard #(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned NUM_GPR = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_set_valid,
    input  logic [ADDR_W-1:0] i_set_addr,
    input  logic              i_clr_valid,
    input  logic [ADDR_W-1:0] i_clr_addr,
    input  logic [ADDR_W-1:0] i_rd_addr_0,
    input  logic [ADDR_W-1:0] i_rd_addr_1,
    output logic              o_hazard_0,
    output logic              o_hazard_1
);

    logic [NUM_GPR-1:0] r_pending;
    logic [NUM_GPR-1:0] w_pending_next;

    // Next pending vector; set is applied after clear so a same-cycle set wins.
    // Addresses at or above NUM_GPR never match a bit and are ignored.
    always_comb begin
        w_pending_next = r_pending;
        for (int i = 0; i < NUM_GPR; i++) begin
            if (i_clr_valid && (i_clr_addr == ADDR_W'(i))) begin
                w_pending_next[i] = 1'b0;
            end
            if (i_set_valid && (i_set_addr == ADDR_W'(i))) begin
                w_pending_next[i] = 1'b1;
            end
        end
    end

    // Pending register, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_next;
        end
    end

    // Hazard lookups; PC-special addresses always read as not pending
    always_comb begin
        o_hazard_0 = 1'b0;
        o_hazard_1 = 1'b0;
        for (int i = 0; i < NUM_GPR; i++) begin
            if (i_rd_addr_0 == ADDR_W'(i)) begin
                o_hazard_0 = r_pending[i];
            end
            if (i_rd_addr_1 == ADDR_W'(i)) begin
                o_hazard_1 = r_pending[i];
            end
        end
    end

endmodule

// File: rtl/zmips_wb_arbiter.sv
// Write-back arbiter: round-robin grant between ALU and load write-back onto the
// single register-file write port, with a registered write stage and scoreboard.
module zmips_wb_arbiter
    import zmips_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned NUM_GPR = zmips_pkg::NUM_GPR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_alu_valid,
    output logic              o_alu_ready,
    input  logic [ADDR_W-1:0] i_alu_addr,
    input  logic [DATA_W-1:0] i_alu_data,
    input  logic              i_mem_valid,
    output logic              o_mem_ready,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [DATA_W-1:0] i_mem_data,
    input  logic              i_hold,
    input  logic              i_issue_valid,
    input  logic [ADDR_W-1:0] i_issue_addr,
    input  logic [ADDR_W-1:0] i_rd_addr_0,
    input  logic [ADDR_W-1:0] i_rd_addr_1,
    output logic              o_hazard_0,
    output logic              o_hazard_1,
    output logic              o_wr,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data
);

    rr_state_e         r_last;
    rr_state_e         w_last_next;
    logic              w_alu_grant;
    logic              w_mem_grant;
    logic              w_xfer;
    logic              w_sel_gpr;
    wb_req_t           w_sel;
    logic              r_wr;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;

    // Grant and round-robin next state; no grant during reset or hold
    always_comb begin
        w_alu_grant = 1'b0;
        w_mem_grant = 1'b0;
        w_last_next = r_last;
        if (!rst && !i_hold) begin
            if (i_alu_valid && (!i_mem_valid || (r_last == LAST_MEM))) begin
                w_alu_grant = 1'b1;
            end else if (i_mem_valid) begin
                w_mem_grant = 1'b1;
            end
        end
        if (w_alu_grant) begin
            w_last_next = LAST_ALU;
        end else if (w_mem_grant) begin
            w_last_next = LAST_MEM;
        end
    end

    // Mux the granted request; writes to PC-special registers are dropped
    always_comb begin
        w_xfer    = w_alu_grant || w_mem_grant;
        w_sel     = '0;
        w_sel.addr = w_mem_grant ? i_mem_addr : i_alu_addr;
        w_sel.data = w_mem_grant ? i_mem_data : i_alu_data;
        w_sel_gpr = (32'(w_sel.addr) < NUM_GPR);
    end

    // Round-robin state register; reset to LAST_MEM so the ALU wins first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= LAST_MEM;
        end else begin
            r_last <= w_last_next;
        end
    end

    // Registered write port; reset discards any in-flight write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr      <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr <= w_xfer && w_sel_gpr;
            if (w_xfer && w_sel_gpr) begin
                r_wr_addr <= w_sel.addr;
                r_wr_data <= w_sel.data;
            end
        end
    end

    zmips_scoreboard #(
        .ADDR_W  (ADDR_W),
        .NUM_GPR (NUM_GPR)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .i_set_valid (i_issue_valid),
        .i_set_addr  (i_issue_addr),
        .i_clr_valid (r_wr),
        .i_clr_addr  (r_wr_addr),
        .i_rd_addr_0 (i_rd_addr_0),
        .i_rd_addr_1 (i_rd_addr_1),
        .o_hazard_0  (o_hazard_0),
        .o_hazard_1  (o_hazard_1)
    );

    assign o_alu_ready = w_alu_grant;
    assign o_mem_ready = w_mem_grant;
    assign o_wr        = r_wr;
    assign o_wr_addr   = r_wr_addr;
    assign o_wr_data   = r_wr_data;

endmodule

// File: tb/tb_zmips_wb_arbiter.sv
// Self-checking bench for zmips_wb_arbiter: table of per-cycle vectors plus
// hand-built hazard and reset sequences; expected writes flow through a queue.
module tb_zmips_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        i_alu_valid;
    logic        o_alu_ready;
    logic [4:0]  i_alu_addr;
    logic [31:0] i_alu_data;
    logic        i_mem_valid;
    logic        o_mem_ready;
    logic [4:0]  i_mem_addr;
    logic [31:0] i_mem_data;
    logic        i_hold;
    logic        i_issue_valid;
    logic [4:0]  i_issue_addr;
    logic [4:0]  i_rd_addr_0;
    logic [4:0]  i_rd_addr_1;
    logic        o_hazard_0;
    logic        o_hazard_1;
    logic        o_wr;
    logic [4:0]  o_wr_addr;
    logic [31:0] o_wr_data;

    zmips_wb_arbiter #(
        .DATA_W  (32),
        .ADDR_W  (5),
        .NUM_GPR (30)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_alu_valid   (i_alu_valid),
        .o_alu_ready   (o_alu_ready),
        .i_alu_addr    (i_alu_addr),
        .i_alu_data    (i_alu_data),
        .i_mem_valid   (i_mem_valid),
        .o_mem_ready   (o_mem_ready),
        .i_mem_addr    (i_mem_addr),
        .i_mem_data    (i_mem_data),
        .i_hold        (i_hold),
        .i_issue_valid (i_issue_valid),
        .i_issue_addr  (i_issue_addr),
        .i_rd_addr_0   (i_rd_addr_0),
        .i_rd_addr_1   (i_rd_addr_1),
        .o_hazard_0    (o_hazard_0),
        .o_hazard_1    (o_hazard_1),
        .o_wr          (o_wr),
        .o_wr_addr     (o_wr_addr),
        .o_wr_data     (o_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic        hold;
        logic        iv;
        logic [4:0]  ia;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic        e_ar;
        logic        e_mr;
        logic        e_h0;
        logic        e_h1;
    } vec_t;

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_wr_t;

    exp_wr_t q[$];
    int n_cmp = 0;
    int n_bad = 0;
    vec_t tbl[15];

    function automatic vec_t mk(
        input logic av, input logic [4:0] aa, input logic [31:0] ad,
        input logic mv, input logic [4:0] ma, input logic [31:0] md,
        input logic hold, input logic iv, input logic [4:0] ia,
        input logic [4:0] r0, input logic [4:0] r1,
        input logic e_ar, input logic e_mr, input logic e_h0, input logic e_h1);
        vec_t v;
        v.av = av; v.aa = aa; v.ad = ad; v.mv = mv; v.ma = ma; v.md = md;
        v.hold = hold; v.iv = iv; v.ia = ia; v.r0 = r0; v.r1 = r1;
        v.e_ar = e_ar; v.e_mr = e_mr; v.e_h0 = e_h0; v.e_h1 = e_h1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_wr(input logic wr, input logic [4:0] addr, input logic [31:0] data);
        exp_wr_t e;
        e.wr = wr; e.addr = addr; e.data = data;
        q.push_back(e);
    endtask

    // One cycle: entered at posedge+1, drives, checks at negedge, returns at posedge+1
    task automatic apply(input vec_t v, input string name);
        exp_wr_t e;
        i_alu_valid = v.av; i_alu_addr = v.aa; i_alu_data = v.ad;
        i_mem_valid = v.mv; i_mem_addr = v.ma; i_mem_data = v.md;
        i_hold = v.hold; i_issue_valid = v.iv; i_issue_addr = v.ia;
        i_rd_addr_0 = v.r0; i_rd_addr_1 = v.r1;
        @(negedge clk);
        chk({name, ".alu_ready"}, 32'(o_alu_ready), 32'(v.e_ar));
        chk({name, ".mem_ready"}, 32'(o_mem_ready), 32'(v.e_mr));
        chk({name, ".hazard_0"}, 32'(o_hazard_0), 32'(v.e_h0));
        chk({name, ".hazard_1"}, 32'(o_hazard_1), 32'(v.e_h1));
        if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s.queue: got empty expected entry", name);
        end else begin
            e = q.pop_front();
            chk({name, ".wr"}, 32'(o_wr), 32'(e.wr));
            if (e.wr) begin
                chk({name, ".wr_addr"}, 32'(o_wr_addr), 32'(e.addr));
                chk({name, ".wr_data"}, o_wr_data, e.data);
            end
        end
        if (v.e_ar && (v.aa < 5'd30)) push_wr(1'b1, v.aa, v.ad);
        else if (v.e_mr && (v.ma < 5'd30)) push_wr(1'b1, v.ma, v.md);
        else push_wr(1'b0, 5'd0, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            av aa     ad            mv ma     md            hd iv ia    r0    r1    ar mr h0 h1
        tbl[0]  = mk(1, 5'd5,  32'hDEADBEEF, 0, 5'd0,  32'h0,        0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0);
        tbl[1]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 5'd0,  32'h0,        1, 5'd31, 32'h11111111, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0);
        tbl[3]  = mk(1, 5'd30, 32'h22222222, 0, 5'd0,  32'h0,        0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0);
        tbl[4]  = mk(0, 5'd0,  32'h0,        1, 5'd30, 32'h33333333, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0);
        tbl[5]  = mk(1, 5'd1,  32'hA1A1A1A1, 1, 5'd2,  32'hB2B2B2B2, 0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0);
        tbl[6]  = mk(1, 5'd1,  32'hA1A1A1A2, 1, 5'd2,  32'hB2B2B2B2, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0);
        tbl[7]  = mk(1, 5'd1,  32'hA1A1A1A2, 1, 5'd2,  32'hB2B2B2B3, 0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0);
        tbl[8]  = mk(1, 5'd1,  32'hA1A1A1A3, 1, 5'd2,  32'hB2B2B2B3, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0);
        tbl[9]  = mk(1, 5'd1,  32'hA1A1A1A3, 1, 5'd2,  32'hB2B2B2B4, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        tbl[10] = mk(1, 5'd1,  32'hA1A1A1A3, 1, 5'd2,  32'hB2B2B2B4, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        tbl[11] = mk(1, 5'd1,  32'hA1A1A1A3, 1, 5'd2,  32'hB2B2B2B4, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        tbl[12] = mk(1, 5'd1,  32'hA1A1A1A3, 1, 5'd2,  32'hB2B2B2B4, 0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0);
        tbl[13] = mk(1, 5'd12, 32'h0000C0DE, 0, 5'd0,  32'h0,        0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0);
        tbl[14] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);

        // Reset with requesters active: no ready, outputs cleared
        rst = 1'b1;
        i_alu_valid = 1'b1; i_alu_addr = 5'd1; i_alu_data = 32'h0;
        i_mem_valid = 1'b1; i_mem_addr = 5'd2; i_mem_data = 32'h0;
        i_hold = 1'b0; i_issue_valid = 1'b0; i_issue_addr = 5'd0;
        i_rd_addr_0 = 5'd0; i_rd_addr_1 = 5'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.alu_ready", 32'(o_alu_ready), 32'd0);
        chk("reset.mem_ready", 32'(o_mem_ready), 32'd0);
        chk("reset.wr", 32'(o_wr), 32'd0);
        chk("reset.wr_addr", 32'(o_wr_addr), 32'd0);
        chk("reset.wr_data", o_wr_data, 32'd0);
        chk("reset.hazard_0", 32'(o_hazard_0), 32'd0);
        i_alu_valid = 1'b0; i_mem_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_wr(1'b0, 5'd0, 32'd0);

        for (int i = 0; i < 15; i++) begin
            apply(tbl[i], $sformatf("tbl%0d", i));
        end

        // Hazard set/clear, set-wins and PC-special issue
        apply(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0,  0, 1, 5'd7,  5'd7,  5'd3,  0, 0, 0, 0), "haz_issue");
        apply(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0,  0, 0, 5'd0,  5'd7,  5'd3,  0, 0, 1, 0), "haz_pend");
        apply(mk(0, 5'd0, 32'h0, 1, 5'd7, 32'h77, 0, 0, 5'd0,  5'd7,  5'd3,  0, 1, 1, 0), "haz_xfer");
        apply(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0,  0, 0, 5'd0,  5'd7,  5'd3,  0, 0, 1, 0), "haz_wrcyc");
        apply(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0,  0, 0, 5'd0,  5'd7,  5'd3,  0, 0, 0, 0), "haz_clr");
        apply(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0,  0, 1, 5'd7,  5'd7,  5'd3,  0, 0, 0, 0), "sw_issue");
        apply(mk(0, 5'd0, 32'h0, 1, 5'd7, 32'h78, 0, 0, 5'd0,  5'd7,  5'd3,  0, 1, 1, 0), "sw_xfer");
        apply(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0,  0, 1, 5'd7,  5'd7,  5'd3,  0, 0, 1, 0), "sw_both");
        apply(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0,  0, 0, 5'd0,  5'd7,  5'd7,  0, 0, 1, 1), "sw_held");
        apply(mk(1, 5'd7, 32'h79, 0, 5'd0, 32'h0, 0, 0, 5'd0,  5'd3,  5'd7,  1, 0, 0, 1), "h1_xfer");
        apply(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0,  0, 0, 5'd0,  5'd3,  5'd7,  0, 0, 0, 1), "h1_wrcyc");
        apply(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0,  0, 0, 5'd0,  5'd3,  5'd7,  0, 0, 0, 0), "h1_clr");
        apply(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0,  0, 1, 5'd30, 5'd30, 5'd31, 0, 0, 0, 0), "pc_issue");
        apply(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0,  0, 0, 5'd0,  5'd30, 5'd31, 0, 0, 0, 0), "pc_look");

        // Reset mid-operation with a write in flight and pending bits 3 and 9
        apply(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0,  0, 1, 5'd3,  5'd3,  5'd9,  0, 0, 0, 0), "rs_set3");
        apply(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0,  0, 1, 5'd9,  5'd3,  5'd9,  0, 0, 1, 0), "rs_set9");
        apply(mk(1, 5'd4, 32'h44, 0, 5'd0, 32'h0, 0, 0, 5'd0,  5'd3,  5'd9,  1, 0, 1, 1), "rs_xfer");
        chk("rs_inflight.wr", 32'(o_wr), 32'd1);
        i_alu_valid = 1'b1; i_mem_valid = 1'b1;
        rst = 1'b1;
        #1;
        chk("rs_async.wr", 32'(o_wr), 32'd0);
        chk("rs_async.hazard_0", 32'(o_hazard_0), 32'd0);
        chk("rs_async.hazard_1", 32'(o_hazard_1), 32'd0);
        chk("rs_async.alu_ready", 32'(o_alu_ready), 32'd0);
        chk("rs_async.mem_ready", 32'(o_mem_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        push_wr(1'b0, 5'd0, 32'd0);
        apply(mk(1, 5'd6, 32'h66, 1, 5'd8, 32'h88, 0, 0, 5'd0,  5'd3,  5'd9,  1, 0, 0, 0), "rs_conflict");
        apply(mk(1, 5'd6, 32'h66, 1, 5'd8, 32'h88, 0, 0, 5'd0,  5'd3,  5'd9,  0, 1, 0, 0), "rs_alt");
        apply(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0,  0, 0, 5'd0,  5'd3,  5'd9,  0, 0, 0, 0), "rs_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/zmips_wb_arbiter.md
# zmips_wb_arbiter

Write-back arbiter and pending-write scoreboard for the zmips 32x32 register file. Shares the register file's single write port between the ALU and memory-load write-back paths using valid/ready handshakes and round-robin priority. Tracks outstanding destination registers so the decode stage can stall on read-after-write hazards. Sits between the execute/memory stages and the register file write port.

## Interface
Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- NUM_GPR, 30, writable general registers; addresses 30 and 31 are PC-special and are never written

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- alu_valid  in  1  ALU write-back request
- alu_ready  out  1  ALU request granted this cycle
- alu_addr  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- mem_valid  in  1  load write-back request
- mem_ready  out  1  load request granted this cycle
- mem_addr  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load data
- hold  in  1  freeze; no grants while high
- issue_valid  in  1  decode issuing an instruction with a destination
- issue_addr  in  ADDR_W  destination of issued instruction
- rd_addr_0, rd_addr_1  in  ADDR_W  decode source registers
- hazard_0, hazard_1  out  1  source register has a pending write
- wr  out  1  register file write enable
- wr_addr  out  ADDR_W  register file write address
- wr_data  out  DATA_W  register file write data

## Operation
- Transfer on a port = valid && ready at a rising edge. A requester holds addr/data stable while valid && !ready.
- Grant, combinational from valids, hold and the round-robin state:
  - hold=1: no grant.
  - One valid: grant it.
  - Both valid: grant the one not granted last.
- Round-robin state is LAST_ALU or LAST_MEM. It updates only on a transfer.
- At most one ready is high per cycle. ready is never high without its valid.
- Accepted transfer with addr < NUM_GPR: register wr=1 with that addr/data for the next cycle.
- Accepted transfer with addr 30 or 31: the handshake completes, wr stays 0 (write dropped), and the scoreboard is unchanged.
- Scoreboard: a NUM_GPR-bit pending vector.
  - Set: issue_valid && issue_addr < NUM_GPR sets bit[issue_addr].
  - Clear: registered wr=1 clears bit[wr_addr].
  - Set and clear of the same bit in the same cycle: set wins.
  - Issue to address 30/31 is ignored.
- hazard_n = pending[rd_addr_n] for rd_addr_n < NUM_GPR, else 0. Combinational.

## Timing
- Reset (async) values:
  - wr=0, wr_addr=0, wr_data=0
  - pending=0, hazard_0=hazard_1=0
  - round-robin state = LAST_MEM, so the ALU wins the first conflict
  - alu_ready=mem_ready=0 while rst is high
- Latency: transfer at edge N gives wr=1 during cycle N+1. The register file writes at edge N+1, and the pending bit clears at edge N+1. hazard drops in cycle N+1 after that edge, when the new value is readable.
- Throughput: one write per cycle. With both requesters valid continuously, grants strictly alternate.
- wr is 0 in any cycle not preceded by a transfer to a GPR. Back-to-back transfers keep wr=1 continuously.
- hold rising mid-stream: no grant in that cycle. A write registered at the prior edge still completes.
- Reset mid-operation: in-flight registered write is discarded (wr forced 0), pending cleared, requesters must re-present.

## Structure
- Shared package zmips_pkg holds:
  - REG_PC_CUR=5'd31, REG_PC_SAVED=5'd30, NUM_GPR=30
  - the round-robin state enum (LAST_ALU, LAST_MEM)
  - the write-back request struct (addr, data)
- One sub-module: zmips_scoreboard, containing the pending vector, set/clear logic and the two hazard lookups. The arbiter top holds the grant logic, round-robin state and output registers.

## Test plan
- Reset then alu_valid=1, alu_addr=5, alu_data=0xDEADBEEF: alu_ready=1 same cycle. Next cycle wr=1, wr_addr=5, wr_data=0xDEADBEEF. Following cycle wr=0.
- Both valid continuously for 4 cycles (alu_addr=1, mem_addr=2): grants ALU, MEM, ALU, MEM. wr_addr sequence 1,2,1,2 with wr held 1.
- issue_valid with issue_addr=7, then rd_addr_0=7: hazard_0=1. mem transfer to 7 at edge N gives hazard_0=0 after edge N+1. Same-cycle issue to 7 during the clearing write leaves hazard_0=1.
- alu transfer to addr 31 and mem transfer to addr 30: both handshakes complete, wr stays 0. issue to 30 gives hazard=0 for rd_addr 30.
- hold=1 with both valid for 3 cycles: both ready=0 and wr=0. On release the ALU is granted first (state LAST_MEM).
- Assert rst while wr=1 and pending bits 3,9 are set: wr=0 and all hazards 0 immediately (async). After rst release the first conflict grants the ALU.
